// File: rtl/urng_pair_packer.sv
// urng_pair_packer: pairs consecutive 32-bit URNG words into a 48-bit u0 and a
// 16-bit u1 sample and buffers the pairs in a first-word-fall-through FIFO.
//
// Optional feature macro: URNG_ZERO_GUARD_EN
//   defined   : pairs whose u0 would be zero are dropped and counted in drop_cnt
//   undefined : every completed pair is pushed, drop_cnt stays 0
//
// Handshake: the head entry transfers on a rising edge where out_valid and
// out_ready are both 1; out_valid never depends on out_ready. The input side
// has no back-pressure, so urng_valid alone qualifies urng_out.
module urng_pair_packer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              urng_out,
    input  logic                     urng_valid,
    output logic [47:0]              u0,
    output logic [15:0]              u1,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     pair_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {
        HALF_EMPTY = 1'b0,
        HALF_FULL  = 1'b1
    } pair_state_t;

    pair_state_t      state;
    pair_state_t      state_next;
    logic             latch_w0;
    logic             pair_done;

    logic [31:0]      w0;
    logic [63:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             full;
    logic             pop;
    logic             push_req;
    logic             push;

    assign pair_state = state;

    // Pairing FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= HALF_EMPTY;
        else       state <= state_next;
    end

    // Pairing FSM next state: advance on every valid word, hold otherwise.
    always_comb begin
        state_next = state;
        if (urng_valid) begin
            case (state)
                HALF_EMPTY: state_next = HALF_FULL;
                HALF_FULL:  state_next = HALF_EMPTY;
                default:    state_next = HALF_EMPTY;
            endcase
        end
    end

    // Pairing FSM outputs: capture the first word or complete the pair.
    always_comb begin
        latch_w0  = 1'b0;
        pair_done = 1'b0;
        if (urng_valid) begin
            if (state == HALF_EMPTY) latch_w0  = 1'b1;
            else                     pair_done = 1'b1;
        end
    end

    // First word of the pair in progress; lost if reset arrives mid-pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         w0 <= '0;
        else if (latch_w0) w0 <= urng_out;
    end

    assign full      = (fifo_level == LVL_W'(DEPTH));
    assign out_valid = (fifo_level != '0);
    assign pop       = out_valid && out_ready;

`ifdef URNG_ZERO_GUARD_EN
    logic pair_zero;
    // u0 = {w0, w1[31:16]} is zero exactly when both of these fields are zero.
    assign pair_zero = (w0 == 32'h0) && (urng_out[31:16] == 16'h0);
    assign push_req  = pair_done && !pair_zero;

    // Saturating count of pairs rejected because log(0) is undefined downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            drop_cnt <= '0;
        else if (pair_done && pair_zero && (drop_cnt != {CNT_W{1'b1}}))
            drop_cnt <= drop_cnt + CNT_W'(1);
    end
`else
    assign push_req = pair_done;
    assign drop_cnt = '0;
`endif

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push = push_req && (!full || pop);

    // Pair storage; contents need no reset because the level qualifies them.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {w0, urng_out};
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Occupancy tracks push/pop on the same edge; simultaneous ones cancel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_level <= '0;
        end else begin
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Sticky flag: a completed pair was lost to a full FIFO with no pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                           overflow <= 1'b0;
        else if (push_req && full && !pop)   overflow <= 1'b1;
    end

    // Head outputs are zeroed while the FIFO is empty.
    always_comb begin
        u0 = '0;
        u1 = '0;
        if (out_valid) begin
            u0 = mem[rd_ptr][63:16];
            u1 = mem[rd_ptr][15:0];
        end
    end

endmodule

// File: tb/tb_urng_pair_packer.sv
// Testbench for urng_pair_packer (DEPTH=4, CNT_W=16). The reference model
// keeps the stored pairs as a queue of 64-bit {w0, w1} values.
module tb_urng_pair_packer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
`ifdef URNG_ZERO_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [31:0]      urng_out = '0;
    logic             urng_valid = 1'b0;
    logic [47:0]      u0;
    logic [15:0]      u1;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [2:0]       fifo_level;
    logic             overflow;
    logic [CNT_W-1:0] drop_cnt;
    logic             pair_state;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // reference model state
    logic [63:0]      exp_q[$];
    logic [31:0]      m_half;
    bit               m_have_half;
    bit               m_ovf;
    int               m_drop;

    urng_pair_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .urng_out   (urng_out),
        .urng_valid (urng_valid),
        .u0         (u0),
        .u1         (u1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .pair_state (pair_state)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    task automatic model_clear();
        exp_q.delete();
        m_have_half = 0;
        m_half = '0;
        m_ovf = 0;
        m_drop = 0;
    endtask

    // What one rising edge does, given the inputs applied before it.
    task automatic model_edge();
        bit pop;
        bit full;
        logic [63:0] pair;
        pop  = (exp_q.size() != 0) && out_ready;
        full = (exp_q.size() == DEPTH);
        if (pop) void'(exp_q.pop_front());
        if (urng_valid) begin
            if (!m_have_half) begin
                m_half = urng_out;
                m_have_half = 1;
            end else begin
                pair = {m_half, urng_out};
                m_have_half = 0;
                if (GUARD && pair[63:16] == 48'h0) begin
                    if (m_drop < (1 << CNT_W) - 1) m_drop++;
                end else if (!full || pop) begin
                    exp_q.push_back(pair);
                end else begin
                    m_ovf = 1;
                end
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        urng_valid = 1'b0;
        out_ready = 1'b0;
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send(input logic [31:0] w);
        urng_out = w;
        urng_valid = 1'b1;
        cycle();
        urng_valid = 1'b0;
    endtask

    function automatic logic [63:0] pk(input logic [31:0] a, input logic [31:0] b);
        return {a, b};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        #3;
        check_cnt++;
        if ({out_valid, u0, u1, fifo_level, overflow, drop_cnt} !== '0)
            $display("FAIL reset_values got v=%b u0=%h u1=%h lvl=%0d ovf=%b drop=%0d exp all 0",
                     out_valid, u0, u1, fifo_level, overflow, drop_cnt);
        else pass_cnt++;
        check_cnt++;
        if (pair_state !== 1'b0) $display("FAIL reset_state got %b exp 0", pair_state);
        else pass_cnt++;
        do_reset();
    endtask

    task automatic test_packing();
        do_reset();
        send(32'hFFF00000);
        check_cnt++;
        if (out_valid !== 1'b0) $display("FAIL pack_half_valid got %b exp 0", out_valid);
        else pass_cnt++;
        send(32'hFF11118F);
        check_cnt++;
        if (out_valid !== 1'b1 || fifo_level !== 3'd1)
            $display("FAIL pack_valid got v=%b lvl=%0d exp v=1 lvl=1", out_valid, fifo_level);
        else pass_cnt++;
        check_cnt++;
        if (u0 !== 48'hFFF00000FF11 || u1 !== 16'h118F)
            $display("FAIL pack_data got %h/%h exp fff00000ff11/118f", u0, u1);
        else pass_cnt++;
    endtask

    task automatic test_gapped();
        int bad = 0;
        do_reset();
        send(32'h12345678);
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (out_valid !== 1'b0) bad++;
        end
        check_cnt++;
        if (bad != 0) $display("FAIL gap_valid_early got %0d high cycles exp 0", bad);
        else pass_cnt++;
        send(32'h9ABCDEF0);
        check_cnt++;
        if (out_valid !== 1'b1 || u0 !== 48'h123456789ABC || u1 !== 16'hDEF0)
            $display("FAIL gap_data got v=%b %h/%h exp v=1 123456789abc/def0", out_valid, u0, u1);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [31:0] w[10];
        do_reset();
        for (int i = 0; i < 10; i++) w[i] = 32'h1000_0001 + 32'h0101_1111 * i;
        for (int i = 0; i < 8; i++) send(w[i]);
        check_cnt++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0)
            $display("FAIL ovf_fill got lvl=%0d ovf=%b exp lvl=4 ovf=0", fifo_level, overflow);
        else pass_cnt++;
        send(w[8]);
        send(w[9]);
        check_cnt++;
        if (fifo_level !== 3'd4 || overflow !== 1'b1)
            $display("FAIL ovf_set got lvl=%0d ovf=%b exp lvl=4 ovf=1", fifo_level, overflow);
        else pass_cnt++;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_cnt++;
            if (out_valid !== 1'b1 || {u0, u1} !== pk(w[2*k], w[2*k+1]))
                $display("FAIL ovf_pop%0d got v=%b %h exp %h", k, out_valid, {u0, u1}, pk(w[2*k], w[2*k+1]));
            else pass_cnt++;
            cycle();
        end
        check_cnt++;
        if (out_valid !== 1'b0 || overflow !== 1'b1)
            $display("FAIL ovf_drain got v=%b ovf=%b exp v=0 ovf=1", out_valid, overflow);
        else pass_cnt++;
        out_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [31:0] w[10];
        do_reset();
        for (int i = 0; i < 10; i++) w[i] = 32'hA000_0003 + 32'h0033_0707 * i;
        for (int i = 0; i < 9; i++) send(w[i]);
        out_ready = 1'b1;
        send(w[9]);
        check_cnt++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0)
            $display("FAIL fpp_level got lvl=%0d ovf=%b exp lvl=4 ovf=0", fifo_level, overflow);
        else pass_cnt++;
        for (int k = 1; k < 5; k++) begin
            check_cnt++;
            if (out_valid !== 1'b1 || {u0, u1} !== pk(w[2*k], w[2*k+1]))
                $display("FAIL fpp_pop%0d got v=%b %h exp %h", k, out_valid, {u0, u1}, pk(w[2*k], w[2*k+1]));
            else pass_cnt++;
            cycle();
        end
        check_cnt++;
        if (out_valid !== 1'b0) $display("FAIL fpp_empty got %b exp 0", out_valid);
        else pass_cnt++;
        out_ready = 1'b0;
    endtask

    task automatic test_zero_guard();
        do_reset();
        send(32'h00000000);
        send(32'h0000ABCD);
        if (GUARD) begin
            check_cnt++;
            if (out_valid !== 1'b0 || drop_cnt !== 16'd1)
                $display("FAIL zg_drop got v=%b drop=%0d exp v=0 drop=1", out_valid, drop_cnt);
            else pass_cnt++;
            for (int i = 0; i < 8; i++) send(32'h5555_0000 + i);
            send(32'h0);
            send(32'h0000_1234);
            check_cnt++;
            if (overflow !== 1'b0 || drop_cnt !== 16'd2 || fifo_level !== 3'd4)
                $display("FAIL zg_full got ovf=%b drop=%0d lvl=%0d exp ovf=0 drop=2 lvl=4",
                         overflow, drop_cnt, fifo_level);
            else pass_cnt++;
        end else begin
            check_cnt++;
            if (out_valid !== 1'b1 || u0 !== 48'h0 || u1 !== 16'hABCD || drop_cnt !== '0)
                $display("FAIL zg_pass got v=%b %h/%h drop=%0d exp v=1 0/abcd drop=0",
                         out_valid, u0, u1, drop_cnt);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [63:0] head;
        int errs = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            urng_valid = ($urandom_range(0, 3) != 0);
            urng_out   = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom();
            out_ready  = ($urandom_range(0, 2) != 0);
            cycle();
            head = (exp_q.size() != 0) ? exp_q[0] : 64'h0;
            check_cnt++;
            if (out_valid !== (exp_q.size() != 0) || {u0, u1} !== head ||
                fifo_level !== 3'(exp_q.size()) || overflow !== m_ovf ||
                drop_cnt !== CNT_W'(m_drop)) begin
                errs++;
                if (errs <= 5)
                    $display("FAIL rand_cycle%0d got v=%b %h lvl=%0d ovf=%b drop=%0d exp %h lvl=%0d ovf=%b drop=%0d",
                             i, out_valid, {u0, u1}, fifo_level, overflow, drop_cnt,
                             head, exp_q.size(), m_ovf, m_drop);
            end else pass_cnt++;
        end
        urng_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 7; i++) send(32'hC0DE_0000 + i);
        check_cnt++;
        if (fifo_level !== 3'd3 || pair_state !== 1'b1)
            $display("FAIL rm_setup got lvl=%0d st=%b exp lvl=3 st=1", fifo_level, pair_state);
        else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        check_cnt++;
        if ({out_valid, u0, u1, fifo_level, overflow, drop_cnt} !== '0)
            $display("FAIL rm_async got v=%b %h/%h lvl=%0d exp all 0", out_valid, u0, u1, fifo_level);
        else pass_cnt++;
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(32'hAAAA_1111);
        send(32'hBBBB_2222);
        check_cnt++;
        if (fifo_level !== 3'd1 || u0 !== 48'hAAAA1111BBBB || u1 !== 16'h2222)
            $display("FAIL rm_pair got lvl=%0d %h/%h exp lvl=1 aaaa1111bbbb/2222", fifo_level, u0, u1);
        else pass_cnt++;
        out_ready = 1'b1;
        cycle();
        check_cnt++;
        if (out_valid !== 1'b0) $display("FAIL rm_single got v=%b exp 0", out_valid);
        else pass_cnt++;
        out_ready = 1'b0;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_packing();
        test_gapped();
        test_overflow();
        test_full_push_pop();
        test_zero_guard();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
